// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: memory opcodes, FSM encoding,
// write-back bundle layout and the default access timeout.
package mem_stage_pkg;

    localparam logic [5:0] OP_LOAD  = 6'b010100;
    localparam logic [5:0] OP_STORE = 6'b010101;

    localparam int unsigned TIMEOUT_CYCLES_DFLT = 64;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StBusy = 2'd1;
    localparam state_t StErr  = 2'd2;

    typedef struct packed {
        logic        we;
        logic [5:0]  op;
        logic [15:0] data;
        logic [1:0]  flag;
    } wb_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_timeout.sv
// BUSY-cycle watchdog for the MEM stage; expired rises on the TIMEOUT_CYCLES-th
// enabled cycle after a clear. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] count_q, count_d;

    assign expired = enable && (count_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory access per LOAD/STORE and stalls
// upstream until mem_ack. Define MEM_TIMEOUT_EN to abort accesses that hang.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_ex,
    input  logic [5:0]  op_ex,
    input  logic [15:0] ans_ex,
    input  logic [15:0] DM_data,
    input  logic [1:0]  flag_ex,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [5:0]  wb_op,
    output logic [15:0] wb_data,
    output logic [1:0]  flag_mem,
    output logic        mem_err
);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wb_valid_q, wb_valid_d;
    wb_t         wb_q, wb_d;

`ifdef MEM_TIMEOUT_EN
    logic err_q, err_d;
    logic expired;

    mem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != StBusy),
        .enable (state_q == StBusy),
        .expired(expired)
    );

    assign mem_err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign mem_err            = 1'b0;
`endif

    assign stall = (state_q != StIdle) || (valid_ex && is_mem_op(op_ex));

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_d       = wb_q;
        wb_valid_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
        err_d      = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (valid_ex) begin
                    if (is_mem_op(op_ex)) begin
                        req_d   = 1'b1;
                        we_d    = (op_ex == OP_STORE);
                        addr_d  = ans_ex;
                        wdata_d = DM_data;
                        state_d = StBusy;
                    end else begin
                        wb_d       = '{we: 1'b1, op: op_ex, data: ans_ex, flag: flag_ex};
                        wb_valid_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (mem_ack) begin
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    state_d    = StIdle;
                    if (we_q) begin
                        wb_d = '{we: 1'b0, op: OP_STORE, data: addr_q, flag: 2'b00};
                    end else begin
                        wb_d = '{we: 1'b1, op: OP_LOAD, data: mem_rdata,
                                 flag: {(mem_rdata == 16'h0000), 1'b0}};
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (expired) begin
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    err_d      = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_d       = '{we: 1'b0, op: (we_q ? OP_STORE : OP_LOAD),
                                   data: addr_q, flag: 2'b00};
                    state_d    = StErr;
                end
`endif
            end
`ifdef MEM_TIMEOUT_EN
            StErr: begin
                state_d = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Sticky abort flag; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_q.we;
    assign wb_op     = wb_q.op;
    assign wb_data   = wb_q.data;
    assign flag_mem  = wb_q.flag;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-backs, a
// negedge monitor pops and compares whenever wb_valid is seen.
module tb_mem_stage;

    localparam logic [5:0] LD  = 6'b010100;
    localparam logic [5:0] ST  = 6'b010101;
    localparam logic [5:0] ALU = 6'b000011;

    logic        clk;
    logic        reset;
    logic        valid_ex;
    logic [5:0]  op_ex;
    logic [15:0] ans_ex;
    logic [15:0] DM_data;
    logic [1:0]  flag_ex;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        wb_valid;
    logic        wb_we;
    logic [5:0]  wb_op;
    logic [15:0] wb_data;
    logic [1:0]  flag_mem;
    logic        mem_err;

    int tests = 0;
    int fails = 0;

    // {we, op, data, flag}
    logic [24:0] exp_q[$];

    mem_stage #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_ex (valid_ex),
        .op_ex    (op_ex),
        .ans_ex   (ans_ex),
        .DM_data  (DM_data),
        .flag_ex  (flag_ex),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .stall    (stall),
        .wb_valid (wb_valid),
        .wb_we    (wb_we),
        .wb_op    (wb_op),
        .wb_data  (wb_data),
        .flag_mem (flag_mem),
        .mem_err  (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && wb_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: got wb %h, required no write-back",
                         {wb_we, wb_op, wb_data, flag_mem});
            end else begin
                logic [24:0] e;
                e = exp_q.pop_front();
                if ({wb_we, wb_op, wb_data, flag_mem} !== e) begin
                    fails++;
                    $display("FAIL wb_bundle: got %h required %h",
                             {wb_we, wb_op, wb_data, flag_mem}, e);
                end
            end
        end
    end

    // One memory access acked in its busy_cycles-th BUSY cycle; hold_* is driven
    // upstream during BUSY and must be ignored until the stage is idle again.
    task automatic mem_op(input logic [5:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata, input int busy_cycles,
                          input logic [24:0] exp_wb, input logic hold_v,
                          input logic [15:0] hold_ans, input logic [1:0] hold_flag);
        step();
        valid_ex = 1'b1;
        op_ex    = op;
        ans_ex   = addr;
        DM_data  = wdata;
        flag_ex  = 2'b11;
        @(negedge clk);
        check("req_cycle_stall", stall, 1);
        check("req_cycle_idle", mem_req, 0);
        step();
        valid_ex  = hold_v;
        op_ex     = ALU;
        ans_ex    = hold_ans;
        flag_ex   = hold_flag;
        DM_data   = 16'hDEAD;
        mem_rdata = 16'h5A5A;
        for (int i = 1; i <= busy_cycles; i++) begin
            if (i == busy_cycles) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                exp_q.push_back(exp_wb);
            end
            @(negedge clk);
            check("busy_req", mem_req, 1);
            check("busy_addr", mem_addr, addr);
            check("busy_we", mem_we, (op == ST));
            check("busy_wdata", mem_wdata, wdata);
            check("busy_stall", stall, 1);
            step();
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'hFFFF;
        @(negedge clk);
        check("done_req", mem_req, 0);
        check("done_we", mem_we, 0);
        check("done_stall", stall, 0);
    endtask

    initial begin
        reset     = 1'b0;
        valid_ex  = 1'b0;
        op_ex     = '0;
        ans_ex    = '0;
        DM_data   = '0;
        flag_ex   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        #3;
        check("rst_mem_req", mem_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_stall", stall, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_flag_mem", flag_mem, 0);
        @(negedge clk);
        reset = 1'b1;

        // Pass-through ALU result, then hold with valid_ex low.
        step();
        valid_ex = 1'b1;
        op_ex    = 6'b000000;
        ans_ex   = 16'h1234;
        flag_ex  = 2'b01;
        exp_q.push_back({1'b1, 6'b000000, 16'h1234, 2'b01});
        @(negedge clk);
        check("pass_stall", stall, 0);
        step();
        valid_ex = 1'b0;
        ans_ex   = 16'h9999;
        @(negedge clk);
        step();
        @(negedge clk);
        check("hold_wb_valid", wb_valid, 0);
        check("hold_wb_data", wb_data, 16'h1234);
        check("hold_flag_mem", flag_mem, 2'b01);

        // Load of zero, acked in the third BUSY cycle.
        mem_op(LD, 16'h0040, 16'h0000, 16'h0000, 3,
               {1'b1, LD, 16'h0000, 2'b10}, 1'b0, 16'h7777, 2'b00);

        // Store with immediate ack.
        mem_op(ST, 16'h0010, 16'hBEEF, 16'h1111, 1,
               {1'b0, ST, 16'h0010, 2'b00}, 1'b0, 16'h7777, 2'b00);

        // Load followed by an ALU op held under stall: one ALU write-back after the load.
        mem_op(LD, 16'h0044, 16'h0000, 16'h00A5, 2,
               {1'b1, LD, 16'h00A5, 2'b00}, 1'b1, 16'h5555, 2'b10);
        exp_q.push_back({1'b1, ALU, 16'h5555, 2'b10});
        step();
        valid_ex = 1'b0;
        @(negedge clk);
        check("b2b_stall", stall, 0);
        step();
        step();

`ifdef MEM_TIMEOUT_EN
        begin
            int n;
            bit gone;
            n    = 0;
            gone = 1'b0;
            step();
            valid_ex = 1'b1;
            op_ex    = LD;
            ans_ex   = 16'h0070;
            exp_q.push_back({1'b0, LD, 16'h0070, 2'b00});
            step();
            valid_ex = 1'b0;
            for (int k = 0; k < 50 && !gone; k++) begin
                @(negedge clk);
                if (mem_req) n++;
                else gone = 1'b1;
            end
            check("timeout_req_cycles", n, 8);
            check("timeout_err", mem_err, 1);
            check("timeout_err_state_stall", stall, 1);
            @(negedge clk);
            check("timeout_stall_released", stall, 0);
            check("timeout_err_sticky", mem_err, 1);
        end
`else
        step();
        valid_ex = 1'b1;
        op_ex    = LD;
        ans_ex   = 16'h0070;
        step();
        valid_ex = 1'b0;
        repeat (20) step();
        @(negedge clk);
        check("no_timeout_req", mem_req, 1);
        check("no_timeout_err", mem_err, 0);
        check("no_timeout_stall", stall, 1);
        step();
        mem_ack   = 1'b1;
        mem_rdata = 16'h0001;
        exp_q.push_back({1'b1, LD, 16'h0001, 2'b00});
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        check("no_timeout_done", stall, 0);
`endif

        // Reset in the middle of a BUSY wait, then a stray ack.
        step();
        valid_ex = 1'b1;
        op_ex    = LD;
        ans_ex   = 16'h0080;
        step();
        valid_ex = 1'b0;
        @(negedge clk);
        check("pre_reset_req", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        check("reset_req_now", mem_req, 0);
        check("reset_stall_now", stall, 0);
        check("reset_addr_now", mem_addr, 0);
        check("reset_wb_data_now", wb_data, 0);
        check("reset_err_now", mem_err, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 16'h4321;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req", mem_req, 0);
        check("late_ack_stall", stall, 0);
        check("late_ack_wb_valid", wb_valid, 0);
        repeat (3) step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
